// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive sequencer and its surroundings.
// master: the sequencer; slave: line/tick source, parity checker and frame consumer.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx_data;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_load;
    logic                 rx_done;
    logic                 parity_flag;
    logic                 stop_err;
    logic                 busy;

    modport master (
        input  baud_tick,
        input  rx_data,
        input  parity_err,
        output data_out,
        output parity_load,
        output rx_done,
        output parity_flag,
        output stop_err,
        output busy
    );

    modport slave (
        output baud_tick,
        output rx_data,
        output parity_err,
        input  data_out,
        input  parity_load,
        input  rx_done,
        input  parity_flag,
        input  stop_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit sampling on an oversampled tick,
// LSB-first word assembly, parity checker strobe and stop-bit validation.
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_EN  = 1'b1
) (
    input logic           clk,
    input logic           rst,
    uart_rx_ctrl_if.master bus
);
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q;
    logic [OS_W-1:0]      os_cnt_q;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 parity_load_q;
    logic                 rx_done_q;
    logic                 parity_flag_q;
    logic                 stop_err_q;
    logic                 busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            data_q        <= '0;
            parity_load_q <= 1'b0;
            rx_done_q     <= 1'b0;
            parity_flag_q <= 1'b0;
            stop_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // Pulses last one clk no matter how sparse baud_tick is.
            parity_load_q <= 1'b0;
            rx_done_q     <= 1'b0;

            // The checker result is valid while parity_load is high, with the
            // full word on data_out and the parity bit still on the line.
            if (parity_load_q) begin
                parity_flag_q <= bus.parity_err;
            end

            if (bus.baud_tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (!bus.rx_data) begin
                            state_q  <= StStart;
                            os_cnt_q <= '0;
                            busy_q   <= 1'b1;
                        end
                    end

                    StStart: begin
                        if (os_cnt_q == OS_MID) begin
                            os_cnt_q <= '0;
                            if (!bus.rx_data) begin
                                state_q   <= StData;
                                bit_cnt_q <= '0;
                            end else begin
                                // Glitch shorter than half a bit: not a start.
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end

                    StData: begin
                        if (os_cnt_q == OS_LAST) begin
                            data_q    <= {bus.rx_data, data_q[DATA_BITS-1:1]};
                            os_cnt_q  <= '0;
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                            if (bit_cnt_q == BC_LAST) begin
                                state_q <= PARITY_EN ? StParity : StStop;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end

                    StParity: begin
                        if (os_cnt_q == OS_LAST) begin
                            parity_load_q <= 1'b1;
                            os_cnt_q      <= '0;
                            state_q       <= StStop;
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end

                    StStop: begin
                        if (os_cnt_q == OS_LAST) begin
                            stop_err_q <= ~bus.rx_data;
                            if (!PARITY_EN) begin
                                parity_flag_q <= 1'b0;
                            end
                            rx_done_q <= 1'b1;
                            os_cnt_q  <= '0;
                            state_q   <= StIdle;
                            busy_q    <= 1'b0;
                        end else begin
                            os_cnt_q <= os_cnt_q + OS_W'(1);
                        end
                    end

                    default: begin
                        state_q  <= StIdle;
                        os_cnt_q <= '0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.parity_load = parity_load_q;
    assign bus.rx_done     = rx_done_q;
    assign bus.parity_flag = parity_flag_q;
    assign bus.stop_err    = stop_err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a parity-enabled receiver ticked every clk and a
// parity-less receiver ticked every 4th clk, driven with directed and random frames.
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ctrl_if #(.DATA_BITS(8)) if1 ();
    uart_rx_ctrl_if #(.DATA_BITS(8)) if2 ();

    uart_rx_ctrl #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1'b1)
    ) u_dut_par (
        .clk(clk),
        .rst(rst),
        .bus(if1.master)
    );

    uart_rx_ctrl #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1'b0)
    ) u_dut_nopar (
        .clk(clk),
        .rst(rst),
        .bus(if2.master)
    );

    assign if1.baud_tick = 1'b1;
    assign if2.baud_tick = (cyc[1:0] == 2'b11);

    // External parity checker: error when the parity bit differs from XOR of the word.
    assign if1.parity_err = if1.parity_load & ((^if1.data_out) ^ if1.rx_data);
    assign if2.parity_err = 1'b0;

    // Frame monitors
    int          done1 = 0, done2 = 0, pl1 = 0, pl2 = 0;
    logic [7:0]  cap_d1 = '0, cap_d2 = '0;
    logic        cap_pf1 = 1'b0, cap_se1 = 1'b0, cap_pf2 = 1'b0, cap_se2 = 1'b0;
    int unsigned done2_cyc = 0;

    always @(negedge clk) begin
        if (if1.rx_done) begin
            done1   <= done1 + 1;
            cap_d1  <= if1.data_out;
            cap_pf1 <= if1.parity_flag;
            cap_se1 <= if1.stop_err;
        end
        if (if1.parity_load) pl1 <= pl1 + 1;
        if (if2.rx_done) begin
            done2     <= done2 + 1;
            cap_d2    <= if2.data_out;
            cap_pf2   <= if2.parity_flag;
            cap_se2   <= if2.stop_err;
            done2_cyc <= cyc;
        end
        if (if2.parity_load) pl2 <= pl2 + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int dut, input logic v);
        if (dut == 1) if1.rx_data = v;
        else          if2.rx_data = v;
    endtask

    // Drives start, data LSB first, optional parity, stop; each bit bit_clks long.
    // abort_clks > 0 returns early after that many clocks, leaving the line as is.
    task automatic send_frame(input int dut, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop, input int bit_clks,
                              input int abort_clks);
        logic [10:0] bits;
        int          n;
        int          elapsed;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (has_par) begin
            bits[9]  = pbit;
            bits[10] = stop;
            n        = 11;
        end else begin
            bits[9] = stop;
            n       = 10;
        end
        elapsed = 0;
        for (int b = 0; b < n; b++) begin
            set_line(dut, bits[b]);
            for (int k = 0; k < bit_clks; k++) begin
                @(negedge clk);
                elapsed++;
                if (abort_clks > 0 && elapsed >= abort_clks) return;
            end
        end
        set_line(dut, 1'b1);
    endtask

    // Sends one frame to the parity receiver and compares against the frame rules.
    task automatic frame1(input string tag, input logic [7:0] d, input logic pbit,
                          input logic stop);
        int d0, p0;
        d0 = done1;
        p0 = pl1;
        send_frame(1, d, 1'b1, pbit, stop, 16, 0);
        repeat (24) @(negedge clk);
        check({tag, "_done"}, 32'(done1 - d0), 32'd1);
        check({tag, "_data"}, 32'(cap_d1), 32'(d));
        check({tag, "_pflag"}, 32'(cap_pf1), 32'(pbit != (^d)));
        check({tag, "_serr"}, 32'(cap_se1), 32'(!stop));
        check({tag, "_pload"}, 32'(pl1 - p0), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic       pb, sb;
        int         d0, p0, d2, p2;
        int unsigned start_cyc;

        rst         = 1'b1;
        if1.rx_data = 1'b1;
        if2.rx_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(if1.data_out), 32'h0);
        check("rst_busy", 32'(if1.busy), 32'h0);
        check("rst_done", 32'(if1.rx_done), 32'h0);
        check("rst_pload", 32'(if1.parity_load), 32'h0);
        check("rst_pflag", 32'(if1.parity_flag), 32'h0);
        check("rst_serr", 32'(if1.stop_err), 32'h0);
        check("rst_busy2", 32'(if2.busy), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame1("a5_p0", 8'hA5, 1'b0, 1'b1);
        frame1("a5_p1", 8'hA5, 1'b1, 1'b1);
        frame1("3c_stop0", 8'h3C, 1'b0, 1'b0);
        frame1("01_ok", 8'h01, 1'b1, 1'b1);

        // Start glitch: low for 4 ticks only
        d0 = done1;
        p0 = pl1;
        if1.rx_data = 1'b0;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", 32'(if1.busy), 32'h1);
        repeat (2) @(negedge clk);
        if1.rx_data = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_lo", 32'(if1.busy), 32'h0);
        check("glitch_nodone", 32'(done1 - d0), 32'h0);
        check("glitch_nopload", 32'(pl1 - p0), 32'h0);
        check("glitch_data_hold", 32'(if1.data_out), 32'h01);

        for (int i = 0; i < 16; i++) begin
            d  = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            frame1($sformatf("rnd%0d", i), d, pb, sb);
        end

        // Leave both flags set, then reset in the middle of data bit 3
        frame1("flags_set", 8'h3C, 1'b1, 1'b0);
        d0 = done1;
        send_frame(1, 8'hFF, 1'b1, 1'b0, 1'b1, 16, 16 + 3 * 16 + 8);
        check("pre_rst_busy", 32'(if1.busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_data", 32'(if1.data_out), 32'h0);
        check("arst_busy", 32'(if1.busy), 32'h0);
        check("arst_pflag", 32'(if1.parity_flag), 32'h0);
        check("arst_serr", 32'(if1.stop_err), 32'h0);
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        if1.rx_data = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_nodone", 32'(done1 - d0), 32'h0);
        frame1("after_rst_5a", 8'h5A, 1'b0, 1'b1);

        // No-parity receiver, tick every 4th clk
        d2 = done2;
        p2 = pl2;
        do @(negedge clk); while (!if2.baud_tick);
        start_cyc = cyc + 1;
        send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 64, 0);
        repeat (80) @(negedge clk);
        check("np_done", 32'(done2 - d2), 32'd1);
        check("np_latency", done2_cyc - start_cyc, 32'((8 + 8 * 16 + 16) * 4));
        check("np_data", 32'(cap_d2), 32'hFF);
        check("np_pflag", 32'(cap_pf2), 32'h0);
        check("np_serr", 32'(cap_se2), 32'h0);

        d = 8'($urandom);
        do @(negedge clk); while (!if2.baud_tick);
        send_frame(2, d, 1'b0, 1'b0, 1'b0, 64, 0);
        repeat (120) @(negedge clk);
        check("np2_done", 32'(done2 - d2), 32'd2);
        check("np2_data", 32'(cap_d2), 32'(d));
        check("np2_serr", 32'(cap_se2), 32'h1);
        check("np2_pflag", 32'(cap_pf2), 32'h0);
        check("np_nopload", 32'(pl2 - p2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
